// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
// Walks a register-write table held in an external synchronous ROM (1-cycle
// read latency) and issues one single-byte I2C write per entry through an
// external I2C master. NACKed entries are retried, exhausted entries are
// counted in ERR/ERR_CNT, and 16'hFFFF marks the end of the table.
// Optional feature macro: I2C_INIT_VERIFY_EN -- every ACKed write is followed
// by a read-back of the same subaddress that must return the written data.
module i2c_init_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h39,
  parameter int          AW         = 8,
  parameter logic [15:0] GAP_CYCLES = 16'd1000,
  parameter int          MAX_RETRY  = 3,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          GO,
  output logic [AW-1:0] TBL_ADDR,
  input  logic [15:0]   TBL_DATA,
  output logic          I2C_START,
  output logic          I2C_READ,
  output logic [6:0]    I2C_ADDR,
  output logic [7:0]    I2C_SUBADDR,
  output logic [7:0]    I2C_WDATA,
  input  logic [7:0]    I2C_RDATA,
  input  logic          I2C_END,
  input  logic          I2C_ACK,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [7:0]    ERR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_XFER,
    S_CHECK,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [7:0]    MAX_RETRY_B = 8'(MAX_RETRY);
  localparam logic [AW-1:0] ADDR_ONE    = AW'(1);

  state_t      state_reg;
  logic        go_sync_reg;
  logic        go_prev_reg;
  logic        auto_pend_reg;
  logic [7:0]  retry_reg;
  logic [15:0] gap_cnt_reg;
  logic        gap_to_issue_reg;  // GAP exits to ISSUE (same entry) instead of FETCH
  logic        start_hold_reg;    // START has been high for at least one cycle
  logic        ack_reg;           // ACK captured when the master went idle

  logic go_rise;
  logic tbl_last;
  logic gap_done;
  logic retry_left;
  logic attempt_pass;
  logic read_next;

  assign go_rise    = go_sync_reg & ~go_prev_reg;
  assign tbl_last   = &TBL_ADDR;
  assign gap_done   = (GAP_CYCLES == 16'd0) || (gap_cnt_reg == GAP_CYCLES - 16'd1);
  assign retry_left = (retry_reg < MAX_RETRY_B);

`ifdef I2C_INIT_VERIFY_EN
  logic [7:0] rdata_reg;

  // Write ACK schedules the read-back; the read decides pass/fail of the attempt.
  always_comb begin
    attempt_pass = 1'b0;
    read_next    = 1'b0;
    if (!I2C_READ) begin
      read_next = ack_reg;
    end else begin
      attempt_pass = ack_reg && (rdata_reg == I2C_WDATA);
    end
  end
`else
  logic rdata_unused;
  assign rdata_unused = ^I2C_RDATA;

  // Without read-back, the write ACK alone decides the attempt.
  always_comb begin
    attempt_pass = ack_reg;
    read_next    = 1'b0;
  end
`endif

  // Main sequencer FSM; every output is a register updated here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg        <= S_IDLE;
      go_sync_reg      <= 1'b0;
      go_prev_reg      <= 1'b0;
      auto_pend_reg    <= AUTO_START;
      retry_reg        <= 8'd0;
      gap_cnt_reg      <= 16'd0;
      gap_to_issue_reg <= 1'b0;
      start_hold_reg   <= 1'b0;
      ack_reg          <= 1'b0;
`ifdef I2C_INIT_VERIFY_EN
      rdata_reg        <= 8'd0;
`endif
      TBL_ADDR         <= '0;
      I2C_START        <= 1'b0;
      I2C_READ         <= 1'b0;
      I2C_ADDR         <= DEV_ADDR;
      I2C_SUBADDR      <= 8'd0;
      I2C_WDATA        <= 8'd0;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      ERR              <= 1'b0;
      ERR_CNT          <= 8'd0;
    end else begin
      go_sync_reg   <= GO;
      go_prev_reg   <= go_sync_reg;
      // The auto-start request only lives for the first cycle after reset.
      auto_pend_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (go_rise || auto_pend_reg) begin
            TBL_ADDR  <= '0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            ERR_CNT   <= 8'd0;
            BUSY      <= 1'b1;
            state_reg <= S_FETCH;
          end
        end

        S_FETCH: begin
          state_reg <= S_DECODE;
        end

        S_DECODE: begin
          if (TBL_DATA == 16'hFFFF) begin
            state_reg <= S_FIN;
          end else begin
            I2C_SUBADDR <= TBL_DATA[15:8];
            I2C_WDATA   <= TBL_DATA[7:0];
            I2C_READ    <= 1'b0;
            retry_reg   <= 8'd0;
            state_reg   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Raise START only on an idle master (it may still be finishing a
          // frame from before a reset), keep it up at least two cycles so the
          // master's registered edge detector sees it, drop it once busy.
          if (!I2C_START) begin
            if (I2C_END) begin
              I2C_START      <= 1'b1;
              start_hold_reg <= 1'b0;
            end
          end else if (!start_hold_reg) begin
            start_hold_reg <= 1'b1;
          end else if (!I2C_END) begin
            I2C_START <= 1'b0;
            state_reg <= S_XFER;
          end
        end

        S_XFER: begin
          if (I2C_END) begin
            ack_reg   <= I2C_ACK;
`ifdef I2C_INIT_VERIFY_EN
            rdata_reg <= I2C_RDATA;
`endif
            state_reg <= S_CHECK;
          end
        end

        S_CHECK: begin
          gap_cnt_reg <= 16'd0;
          if (read_next) begin
            I2C_READ         <= 1'b1;
            gap_to_issue_reg <= 1'b1;
            state_reg        <= S_GAP;
          end else if (!attempt_pass && retry_left) begin
            // Retry always restarts with the write of the latched entry.
            retry_reg        <= retry_reg + 8'd1;
            I2C_READ         <= 1'b0;
            gap_to_issue_reg <= 1'b1;
            state_reg        <= S_GAP;
          end else begin
            if (!attempt_pass) begin
              ERR <= 1'b1;
              if (ERR_CNT != 8'hFF) begin
                ERR_CNT <= ERR_CNT + 8'd1;
              end
            end
            if (tbl_last) begin
              // Running off the end of the table counts as a missing marker.
              ERR       <= 1'b1;
              state_reg <= S_FIN;
            end else begin
              TBL_ADDR         <= TBL_ADDR + ADDR_ONE;
              gap_to_issue_reg <= 1'b0;
              state_reg        <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_done) begin
            state_reg <= gap_to_issue_reg ? S_ISSUE : S_FETCH;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
          end
        end

        S_FIN: begin
          DONE      <= 1'b1;
          BUSY      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed testbench for i2c_init_sequencer with a behavioural I2C master and
// a synchronous table ROM. Read-back scenarios run only when the
// I2C_INIT_VERIFY_EN macro is defined.
module tb_i2c_init_sequencer;

  localparam logic [15:0] GAP = 16'd20;
`ifdef I2C_INIT_VERIFY_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        GO = 1'b0;
  logic [7:0]  TBL_ADDR;
  logic [15:0] TBL_DATA;
  logic        I2C_START, I2C_READ;
  logic [6:0]  I2C_ADDR;
  logic [7:0]  I2C_SUBADDR, I2C_WDATA, I2C_RDATA;
  logic        I2C_END, I2C_ACK;
  logic        BUSY, DONE, ERR;
  logic [7:0]  ERR_CNT;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  i2c_init_sequencer #(
    .DEV_ADDR(7'h39), .AW(8), .GAP_CYCLES(GAP), .MAX_RETRY(3), .AUTO_START(1'b1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .GO(GO),
    .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .I2C_START(I2C_START), .I2C_READ(I2C_READ), .I2C_ADDR(I2C_ADDR),
    .I2C_SUBADDR(I2C_SUBADDR), .I2C_WDATA(I2C_WDATA), .I2C_RDATA(I2C_RDATA),
    .I2C_END(I2C_END), .I2C_ACK(I2C_ACK),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  // Table ROM, one cycle read latency
  logic [15:0] rom [0:255];
  always @(posedge CLK) TBL_DATA <= rom[TBL_ADDR];

  // Master model configuration (driven by the stimulus process)
  logic       m_rst = 1'b1;
  logic       log_clr = 1'b0;
  int         xfer_len = 6;
  logic [7:0] nack_sub = 8'h00;
  int         nack_41_first = 0;
  logic       bad_rd = 1'b0;

  // Master model state and transaction log
  logic       start_d, busy_m, cur_read;
  logic [7:0] cur_sub, cur_wdata;
  int         cnt_m, cur_idx, log_n, attempts_41, viol, cyc, last_end;
  logic [7:0] log_sub [0:31];
  logic [7:0] log_wd  [0:31];
  logic       log_rd  [0:31];
  logic [6:0] log_adr [0:31];
  int         log_st  [0:31];
  int         log_en  [0:31];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (m_rst) begin
      cyc <= 0; start_d <= 1'b0; busy_m <= 1'b0; cur_read <= 1'b0;
      cur_sub <= 8'h00; cur_wdata <= 8'h00; cnt_m <= 0; cur_idx <= -1;
      log_n <= 0; attempts_41 <= 0; viol <= 0; last_end <= 0;
      I2C_END <= 1'b1; I2C_ACK <= 1'b0; I2C_RDATA <= 8'h00;
    end else begin
      start_d <= I2C_START;
      if (log_clr) begin
        log_n <= 0; cur_idx <= -1; attempts_41 <= 0; viol <= 0;
      end
      if (I2C_START && !start_d) begin
        if (busy_m) begin
          viol <= viol + 1;
        end else begin
          busy_m <= 1'b1; I2C_END <= 1'b0; cnt_m <= xfer_len;
          cur_sub <= I2C_SUBADDR; cur_wdata <= I2C_WDATA; cur_read <= I2C_READ;
          if (!log_clr && log_n < 32) begin
            log_sub[log_n] <= I2C_SUBADDR; log_wd[log_n] <= I2C_WDATA;
            log_rd[log_n] <= I2C_READ; log_adr[log_n] <= I2C_ADDR;
            log_st[log_n] <= cyc; cur_idx <= log_n; log_n <= log_n + 1;
          end
          if (!log_clr && I2C_SUBADDR == 8'h41 && !I2C_READ) attempts_41 <= attempts_41 + 1;
        end
      end else if (busy_m) begin
        if (cnt_m <= 1) begin
          busy_m <= 1'b0; I2C_END <= 1'b1; last_end <= cyc;
          if (cur_idx >= 0 && !log_clr) log_en[cur_idx] <= cyc;
          I2C_ACK <= !(cur_sub == nack_sub) &&
                     !(cur_sub == 8'h41 && !cur_read && attempts_41 <= nack_41_first);
          I2C_RDATA <= cur_wdata ^ ((bad_rd && cur_sub == 8'h41) ? 8'h01 : 8'h00);
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end

  task automatic pulse_go();
    @(negedge CLK); GO = 1'b1;
    repeat (2) @(negedge CLK);
    GO = 1'b0;
  endtask

  task automatic clear_log();
    @(negedge CLK); log_clr = 1'b1;
    @(negedge CLK); log_clr = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLK);
      if (DONE && !BUSY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [43:0] got, exp;
    repeat (2) @(negedge CLK);
    m_rst = 1'b0;
    repeat (2) @(negedge CLK);
    got = {TBL_ADDR, I2C_ADDR, I2C_START, I2C_READ, I2C_SUBADDR, I2C_WDATA, BUSY, DONE, ERR, ERR_CNT};
    exp = {8'h00, 7'h39, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    checks++;
    if (got !== exp) begin fails++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
    $display("reset: outputs %h", got);
  endtask

  task automatic test_basic();
    bit ok;
    @(negedge CLK); RESET = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL basic_timeout: DONE not seen"); end
    checks++;
    if (log_n !== 2 * STRIDE) begin fails++; $display("FAIL basic_count: got %0d expected %0d", log_n, 2 * STRIDE); end
    checks++;
    if ({log_adr[0], log_sub[0], log_wd[0], log_rd[0]} !== {7'h39, 8'h41, 8'h10, 1'b0}) begin
      fails++; $display("FAIL basic_entry0: got %h/%h/%h/%b expected 39/41/10/0", log_adr[0], log_sub[0], log_wd[0], log_rd[0]);
    end
    checks++;
    if ({log_adr[STRIDE], log_sub[STRIDE], log_wd[STRIDE], log_rd[STRIDE]} !== {7'h39, 8'h98, 8'h03, 1'b0}) begin
      fails++; $display("FAIL basic_entry1: got %h/%h/%h/%b expected 39/98/03/0", log_adr[STRIDE], log_sub[STRIDE], log_wd[STRIDE], log_rd[STRIDE]);
    end
    checks++;
    if ({DONE, ERR, ERR_CNT, BUSY, TBL_ADDR} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd2}) begin
      fails++; $display("FAIL basic_status: got DONE=%b ERR=%b CNT=%0d BUSY=%b ADDR=%0d expected 1 0 0 0 2", DONE, ERR, ERR_CNT, BUSY, TBL_ADDR);
    end
    $display("basic: %0d transactions, DONE=%b ERR=%b TBL_ADDR=%0d", log_n, DONE, ERR, TBL_ADDR);
  endtask

`ifdef I2C_INIT_VERIFY_EN
  task automatic test_verify_mismatch();
    bit ok;
    bit pairs_ok;
    bad_rd = 1'b1;
    clear_log();
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL verify_bad_timeout: DONE not seen"); end
    checks++;
    if (log_n !== 10) begin fails++; $display("FAIL verify_bad_count: got %0d expected 10", log_n); end
    pairs_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (log_sub[2*k] !== 8'h41 || log_rd[2*k] !== 1'b0 || log_sub[2*k+1] !== 8'h41 || log_rd[2*k+1] !== 1'b1)
        pairs_ok = 1'b0;
    end
    checks++;
    if (!pairs_ok) begin fails++; $display("FAIL verify_bad_pairs: write/read pairs on 0x41 not as required"); end
    checks++;
    if ({ERR, ERR_CNT, DONE} !== {1'b1, 8'd1, 1'b1}) begin
      fails++; $display("FAIL verify_bad_status: got ERR=%b CNT=%0d DONE=%b expected 1 1 1", ERR, ERR_CNT, DONE);
    end
    bad_rd = 1'b0;
    $display("verify_mismatch: %0d transactions, ERR=%b ERR_CNT=%0d", log_n, ERR, ERR_CNT);
  endtask

  task automatic test_verify_ok();
    bit ok;
    clear_log();
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL verify_ok_timeout: DONE not seen"); end
    checks++;
    if (log_n !== 4 || log_rd[0] !== 1'b0 || log_rd[1] !== 1'b1 || log_sub[1] !== 8'h41) begin
      fails++; $display("FAIL verify_ok_log: got n=%0d rd0=%b rd1=%b sub1=%h expected 4 0 1 41", log_n, log_rd[0], log_rd[1], log_sub[1]);
    end
    checks++;
    if (ERR !== 1'b0) begin fails++; $display("FAIL verify_ok_err: got %b expected 0", ERR); end
    $display("verify_ok: %0d transactions, ERR=%b", log_n, ERR);
  endtask
`else
  task automatic test_retry();
    bit ok;
    nack_41_first = 2;
    clear_log();
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL retry_timeout: DONE not seen"); end
    checks++;
    if ({log_sub[0], log_sub[1], log_sub[2], log_sub[3]} !== {8'h41, 8'h41, 8'h41, 8'h98} || log_n !== 4) begin
      fails++; $display("FAIL retry_seq: got n=%0d %h %h %h %h expected 4 41 41 41 98", log_n, log_sub[0], log_sub[1], log_sub[2], log_sub[3]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (log_st[k+1] - log_en[k] < int'(GAP)) begin
        fails++; $display("FAIL retry_gap%0d: got %0d cycles expected >= %0d", k, log_st[k+1] - log_en[k], GAP);
      end
    end
    checks++;
    if ({ERR, ERR_CNT, DONE} !== {1'b0, 8'd0, 1'b1}) begin
      fails++; $display("FAIL retry_status: got ERR=%b CNT=%0d DONE=%b expected 0 0 1", ERR, ERR_CNT, DONE);
    end
    nack_41_first = 0;
    $display("retry: %0d transactions, ERR=%b", log_n, ERR);
  endtask

  task automatic test_fail();
    bit ok;
    int n98;
    nack_sub = 8'h98;
    clear_log();
    pulse_go();
    wait_done(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL fail_timeout: DONE not seen"); end
    n98 = 0;
    for (int k = 0; k < 32; k++) if (k < log_n && log_sub[k] == 8'h98) n98++;
    checks++;
    if (n98 !== 4 || log_n !== 5) begin fails++; $display("FAIL fail_attempts: got %0d of %0d expected 4 of 5", n98, log_n); end
    checks++;
    if ({ERR, ERR_CNT, DONE, TBL_ADDR} !== {1'b1, 8'd1, 1'b1, 8'd2}) begin
      fails++; $display("FAIL fail_status: got ERR=%b CNT=%0d DONE=%b ADDR=%0d expected 1 1 1 2", ERR, ERR_CNT, DONE, TBL_ADDR);
    end
    nack_sub = 8'h00;
    $display("fail: %0d attempts at 0x98, ERR=%b ERR_CNT=%0d", n98, ERR, ERR_CNT);
  endtask

  task automatic test_go_busy();
    bit ok;
    clear_log();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (busy_m) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL gobusy_xfer: no transfer started"); end
    checks++;
    if ({DONE, ERR, ERR_CNT} !== {1'b0, 1'b0, 8'd0}) begin
      fails++; $display("FAIL gobusy_clear: got DONE=%b ERR=%b CNT=%0d expected 0 0 0", DONE, ERR, ERR_CNT);
    end
    pulse_go();
    wait_done(ok);
    repeat (10) @(negedge CLK);
    checks++;
    if (!ok || BUSY !== 1'b0 || log_n !== 2) begin
      fails++; $display("FAIL gobusy_ignored: got ok=%b BUSY=%b n=%0d expected 1 0 2", ok, BUSY, log_n);
    end
    pulse_go();
    checks++;
    if ({BUSY, DONE, TBL_ADDR} !== {1'b1, 1'b0, 8'd0}) begin
      fails++; $display("FAIL gobusy_restart: got BUSY=%b DONE=%b ADDR=%0d expected 1 0 0", BUSY, DONE, TBL_ADDR);
    end
    wait_done(ok);
    checks++;
    if (!ok || log_n !== 4 || log_sub[2] !== 8'h41) begin
      fails++; $display("FAIL gobusy_rerun: got ok=%b n=%0d sub2=%h expected 1 4 41", ok, log_n, log_sub[2]);
    end
    $display("go_busy: %0d transactions over two runs", log_n);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int inflight_end;
    xfer_len = 40;
    clear_log();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (log_n == 2 && busy_m) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL rstmid_reach: entry 1 transfer not seen"); end
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++;
    if ({I2C_START, BUSY, TBL_ADDR, I2C_SUBADDR, I2C_WDATA} !== {1'b0, 1'b0, 8'd0, 8'h00, 8'h00}) begin
      fails++; $display("FAIL rstmid_async: got START=%b BUSY=%b ADDR=%0d SUB=%h WD=%h expected 0 0 0 00 00",
                        I2C_START, BUSY, TBL_ADDR, I2C_SUBADDR, I2C_WDATA);
    end
    clear_log();
    @(negedge CLK); RESET = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy_m) begin ok = 1'b1; break; end
    end
    inflight_end = last_end;
    checks++;
    if (!ok || log_n !== 0) begin fails++; $display("FAIL rstmid_stall: got idle=%b n=%0d expected 1 0", ok, log_n); end
    wait_done(ok);
    checks++;
    if (!ok || viol !== 0 || log_n !== 2 || log_st[0] <= inflight_end) begin
      fails++; $display("FAIL rstmid_rerun: got ok=%b viol=%0d n=%0d start0=%0d end=%0d expected 1 0 2 start0>end",
                        ok, viol, log_n, log_st[0], inflight_end);
    end
    xfer_len = 6;
    $display("reset_mid: first START at cycle %0d after in-flight end at %0d", log_st[0], inflight_end);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h4110;
    rom[1] = 16'h9803;
    #3 RESET = 1'b1;
    test_reset();
    test_basic();
`ifdef I2C_INIT_VERIFY_EN
    test_verify_mismatch();
    test_verify_ok();
`else
    test_retry();
    test_fail();
    test_go_busy();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Upstream feeder for the I2C master: walks a register-write table and issues one single-byte write per entry.
- Per entry: pulses the master's start, waits for transaction end, checks ACK, retries on NACK.
- Used to configure video/audio codecs (e.g. HDMI transmitter) after power-up or on request.
- Table is an external synchronous ROM with 1-cycle read latency.

Parameters:
- DEV_ADDR, 7'h39: 7-bit I2C device address driven on I2C_ADDR.
- AW, 8: table address width.
- GAP_CYCLES, 16'd1000: idle CLK cycles between transactions, and before each retry.
- MAX_RETRY, 3: retries per entry after the first NACK. Total attempts = MAX_RETRY+1.
- AUTO_START, 1: when 1, a sequence runs automatically once after reset release.

Ports:
- CLK  in  1  system clock, same clock as the I2C master.
- RESET  in  1  asynchronous, active-high reset.
- GO  in  1  rising edge starts a sequence. Ignored while BUSY=1.
- TBL_ADDR  out  AW  table read address.
- TBL_DATA  in  16  table word: [15:8] subaddress, [7:0] data. 16'hFFFF is the end marker.
- I2C_START  out  1  start request to master. Master acts on the rising edge.
- I2C_READ  out  1  transaction type. 0 = write.
- I2C_ADDR  out  7  device address.
- I2C_SUBADDR  out  8  register subaddress.
- I2C_WDATA  out  8  write data.
- I2C_RDATA  in  8  read data from master. Used only with the optional feature.
- I2C_END  in  1  master idle flag. 1 = idle/finished.
- I2C_ACK  in  1  master ACK result, valid when I2C_END rises.
- BUSY  out  1  sequence in progress.
- DONE  out  1  set when the end marker is reached; cleared on the next start.
- ERR  out  1  sticky: at least one entry exhausted its retries; cleared on the next start.
- ERR_CNT  out  8  number of failed entries, saturating at 255.

Behaviour:
- Reset values:
  - All outputs 0, except TBL_ADDR=0 and I2C_ADDR=DEV_ADDR.
  - State IDLE, retry counter 0, gap counter 0.
- Start condition: GO rising edge (registered, edge-detected), or the first cycle after reset release when AUTO_START=1.
  - On start: TBL_ADDR<=0, DONE<=0, ERR<=0, ERR_CNT<=0, BUSY<=1, go to FETCH.
- FETCH: one wait cycle for ROM latency, then go to DECODE.
- DECODE:
  - TBL_DATA==16'hFFFF: go to FIN.
  - Otherwise latch I2C_SUBADDR<=TBL_DATA[15:8] and I2C_WDATA<=TBL_DATA[7:0], drive I2C_READ<=0, clear retry counter, go to ISSUE.
- ISSUE: I2C_START<=1. Hold it until I2C_END==0 is seen, then I2C_START<=0 and go to XFER.
  - START must stay high for at least 2 CLK cycles, because the master edge-detects through a register.
- XFER: wait for I2C_END==1, then go to CHECK.
- CHECK:
  - I2C_ACK==1: entry passes. TBL_ADDR<=TBL_ADDR+1, go to GAP.
  - NACK with retry<MAX_RETRY: retry++, go to GAP, then re-issue the same entry. Skip FETCH; latched fields are reused.
  - NACK with retry==MAX_RETRY: ERR<=1, ERR_CNT++ (saturating), TBL_ADDR+1, go to GAP.
- GAP:
  - Count GAP_CYCLES cycles.
  - After a pass or a failed entry, go to FETCH.
  - After a NACK that still has retries left, go to ISSUE.
  - GAP_CYCLES=0 means a single-cycle pass-through.
- FIN: DONE<=1, BUSY<=0, go to IDLE.
- TBL_ADDR wrap: if TBL_ADDR would wrap from all-ones to 0 with no marker seen, treat it as the end marker. Go to FIN with ERR<=1.
- GO while BUSY: ignored; no queued restart.
- RESET mid-transaction:
  - I2C_START drops to 0 immediately.
  - The master may still finish its current frame; the sequencer does not wait for it.
  - On the next start, ISSUE stalls until I2C_END==1 before raising I2C_START.
- Timeout: none. Liveness relies on I2C_END.

Optional Feature:
- Macro: I2C_INIT_VERIFY_EN.
- When defined:
  - After an ACKed write, issue a read of the same subaddress: I2C_READ<=1, ISSUE/XFER again.
  - The entry passes only if the read ACKs and I2C_RDATA==I2C_WDATA.
  - A mismatch or NACK counts as one failed attempt under the same retry rules; the retry restarts with the write.
  - GAP is inserted between the write and the read.
- When undefined: I2C_RDATA is unused and the write ACK alone decides the entry.

Test Plan:
- Table {0x4110, 0x9803, 0xFFFF}, slave always ACKs, AUTO_START=1.
  - Expect two writes to DEV_ADDR: (0x41,0x10) then (0x98,0x03).
  - DONE=1, ERR=0, ERR_CNT=0, BUSY=0. TBL_ADDR ends at 2.
- Slave NACKs the first two attempts at entry 0, then ACKs, MAX_RETRY=3.
  - Expect three start pulses for subaddress 0x41, separated by ≥GAP_CYCLES.
  - ERR=0, and entry 1 is still written.
- Slave always NACKs subaddress 0x98.
  - Expect exactly 4 attempts at 0x98, ERR=1, ERR_CNT=1.
  - The sequence continues to the marker; DONE=1.
- Assert GO during a transfer; after DONE, assert GO again.
  - The first GO is ignored. The second restarts at TBL_ADDR=0 and clears DONE/ERR.
- Assert RESET during XFER of entry 1, with the master still busy.
  - All outputs return to reset values asynchronously.
  - After release, the first I2C_START rises only after I2C_END==1.
- With I2C_INIT_VERIFY_EN defined and readback returning 0x11 for written 0x10:
  - Expect 4 write+read pairs, then ERR=1.
  - With correct readback: one pair, pass.
